// File: rtl/imem_prefetch_queue.sv
// imem_prefetch_queue: instruction fetch unit with its own PC, an internal
// word-organised RAM (read latency MEM_LAT), a DEPTH-entry return queue and a
// valid/ready output toward decode. A redirect flushes the queue and squashes
// reads in flight; a write port loads the program.
//
// Optional feature macro: IMEM_MISALIGN_CHECK_EN
//   defined   -> adds a sticky misalign_err output, set the cycle after a
//                redirect whose target has nonzero low address bits.
//   undefined -> no misalign_err port; misaligned targets are aligned down.
//
// Handshake: an entry transfers on a rising edge where out_valid and
// out_ready are both 1; while out_valid=1 and out_ready=0 the head entry
// (out_instr/out_pc) is held unchanged. out_valid never depends
// combinationally on out_ready.
module imem_prefetch_queue #(
    parameter int                     INS_ADDRESS = 9,
    parameter int                     INS_W       = 32,
    parameter int                     DEPTH       = 4,
    parameter int                     MEM_LAT     = 1,
    parameter logic [INS_ADDRESS-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   redirect_valid,
    input  logic [INS_ADDRESS-1:0] redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INS_W-1:0]       out_instr,
    output logic [INS_ADDRESS-1:0] out_pc,
    input  logic                   wr_en,
    input  logic [INS_ADDRESS-1:0] wr_addr,
    input  logic [INS_W-1:0]       wr_data
`ifdef IMEM_MISALIGN_CHECK_EN
    ,
    output logic                   misalign_err
`endif
);

    localparam int WA    = INS_ADDRESS - 2;
    localparam int WORDS = 2 ** WA;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    // Program storage; never reset.
    logic [INS_W-1:0]       mem [WORDS];

    // Fetch state.
    logic [INS_ADDRESS-1:0] fetch_pc;
    logic                   issue;
    int                     inflight;

    // In-flight read pipeline: valid bit, byte address and returned data.
    logic [MEM_LAT-1:0]     pipe_v;
    logic [INS_ADDRESS-1:0] pipe_pc   [MEM_LAT];
    logic [INS_W-1:0]       data_pipe [MEM_LAT];
    logic                   push;
    logic                   pop;

    // Return queue.
    logic [INS_W-1:0]       q_instr [DEPTH];
    logic [INS_ADDRESS-1:0] q_pc    [DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [CW-1:0]          count;

    // Last presented head, shown while the queue is empty.
    logic [INS_W-1:0]       hold_instr;
    logic [INS_ADDRESS-1:0] hold_pc;

    // Low address bits carry no information for word accesses.
    logic                   unused_ok;
    assign unused_ok = ^{wr_addr[1:0], redirect_pc[1:0]};

    // Count reads still travelling through the RAM pipeline.
    always_comb begin
        inflight = 0;
        for (int i = 0; i < MEM_LAT; i++) begin
            inflight = inflight + int'(pipe_v[i]);
        end
    end

    // Issue only when every queued and in-flight entry still has a slot.
    assign issue     = !reset && !redirect_valid && ((int'(count) + inflight) < DEPTH);
    assign push      = pipe_v[MEM_LAT-1] && !reset && !redirect_valid;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign out_instr = out_valid ? q_instr[rd_ptr] : hold_instr;
    assign out_pc    = out_valid ? q_pc[rd_ptr]    : hold_pc;

    // Fetch PC: reset, redirect (aligned down), or advance by one word on issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[INS_ADDRESS-1:2], 2'b00};
        end else if (issue) begin
            fetch_pc <= fetch_pc + INS_ADDRESS'(4);
        end
    end

    // RAM write (read-first) and the data/address side of the read pipeline.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr[INS_ADDRESS-1:2]] <= wr_data;
        end
        data_pipe[0] <= mem[fetch_pc[INS_ADDRESS-1:2]];
        pipe_pc[0]   <= fetch_pc;
        for (int k = 1; k < MEM_LAT; k++) begin
            data_pipe[k] <= data_pipe[k-1];
            pipe_pc[k]   <= pipe_pc[k-1];
        end
    end

    // In-flight valid bits; reset and redirect squash every outstanding read.
    always_ff @(posedge clk) begin
        if (reset || redirect_valid) begin
            pipe_v <= '0;
        end else begin
            pipe_v[0] <= issue;
            for (int k = 1; k < MEM_LAT; k++) begin
                pipe_v[k] <= pipe_v[k-1];
            end
        end
    end

    // Queue storage: returning reads land at the write pointer.
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[wr_ptr] <= data_pipe[MEM_LAT-1];
            q_pc[wr_ptr]    <= pipe_pc[MEM_LAT-1];
        end
    end

    // Queue pointers and occupancy; flushed on reset or redirect.
    always_ff @(posedge clk) begin
        if (reset || redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Remember the most recently presented head for the empty-queue outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_instr <= '0;
            hold_pc    <= '0;
        end else if (out_valid) begin
            hold_instr <= q_instr[rd_ptr];
            hold_pc    <= q_pc[rd_ptr];
        end
    end

`ifdef IMEM_MISALIGN_CHECK_EN
    // Sticky flag for a redirect to a non-word-aligned target.
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_err <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            misalign_err <= 1'b1;
        end
    end
`endif

endmodule
